// File: rtl/g1_pkg.sv
// Shared definitions for the execute stage: word and field widths, the ALU command
// encoding and the iterative-multiplier FSM states.
package g1_pkg;

  localparam int unsigned WORD_LEN          = 16;
  localparam int unsigned REG_FILE_ADDR_LEN = 4;
  localparam int unsigned EXE_CMD_LEN       = 4;

  typedef enum logic [EXE_CMD_LEN-1:0] {
    CmdNop = 4'd0,
    CmdAdd = 4'd1,
    CmdSub = 4'd2,
    CmdAnd = 4'd3,
    CmdOr  = 4'd4,
    CmdXor = 4'd5,
    CmdShl = 4'd6,
    CmdShr = 4'd7,
    CmdMov = 4'd8,
    CmdMul = 4'd9
  } exe_cmd_e;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } mul_state_e;

  // Codes the stage actually executes; everything else behaves as NOP with WB_EN dropped.
  function automatic logic is_exec_cmd(input logic [EXE_CMD_LEN-1:0] cmd, input logic mul_en);
    return (cmd <= CmdMov) || (mul_en && (cmd == CmdMul));
  endfunction

endpackage

// File: rtl/mul_iter.sv
// 16-iteration shift-add multiplier; returns the low WORD_LEN bits of a*b.
// done marks the cycle whose closing edge performs the last iteration.
module mul_iter
  import g1_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WORD_LEN-1:0] a,
  input  logic [WORD_LEN-1:0] b,
  output logic                done,
  output logic [WORD_LEN-1:0] product
);

  mul_state_e          state_q, state_d;
  logic [3:0]          cnt_q;
  logic [WORD_LEN-1:0] mcand_q, mplier_q, acc_q, acc_next;

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done     = (state_q == StRun) && (cnt_q == 4'hF);
  // Valid as the final product while done is high.
  assign product  = acc_next;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (cnt_q == 4'hF) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (state_q == StIdle) begin
      if (start) begin
        cnt_q    <= '0;
        mcand_q  <= a;
        mplier_q <= b;
        acc_q    <= '0;
      end
    end else begin
      cnt_q    <= cnt_q + 4'd1;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_next;
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ID/EXE register, ALU, optional iterative multiplier and EXE/MEM register.
// Define EXE_MUL_EN to build the multiplier; otherwise code 9 is a NOP and busy is tied low.
module exe_stage
  import g1_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         freeze,
  input  logic [EXE_CMD_LEN-1:0]       EXE_CMD,
  input  logic                         MEM_R_EN,
  input  logic                         MEM_W_EN,
  input  logic                         WB_EN,
  input  logic [REG_FILE_ADDR_LEN-1:0] dest,
  input  logic [WORD_LEN-1:0]          val1,
  input  logic [WORD_LEN-1:0]          val2,
  input  logic [WORD_LEN-1:0]          st_val,
  output logic [WORD_LEN-1:0]          alu_result,
  output logic [WORD_LEN-1:0]          st_val_EXE,
  output logic [REG_FILE_ADDR_LEN-1:0] dest_EXE,
  output logic                         WB_EN_EXE,
  output logic                         MEM_R_EN_EXE,
  output logic                         MEM_W_EN_EXE,
  output logic                         busy,
  output logic                         flagZ
);

`ifdef EXE_MUL_EN
  localparam logic MulEn = 1'b1;
`else
  localparam logic MulEn = 1'b0;
`endif

  logic [EXE_CMD_LEN-1:0]       cmd_q;
  logic                         wb_q, mem_r_q, mem_w_q;
  logic [REG_FILE_ADDR_LEN-1:0] dest_q;
  logic [WORD_LEN-1:0]          val1_q, val2_q, st_q;
  logic [WORD_LEN-1:0]          alu_res;
  logic                         cmd_exec, flag_upd, out_bubble;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q   <= CmdNop;
      wb_q    <= 1'b0;
      mem_r_q <= 1'b0;
      mem_w_q <= 1'b0;
      dest_q  <= '0;
      val1_q  <= '0;
      val2_q  <= '0;
      st_q    <= '0;
    end else if (!busy) begin
      if (flush || freeze) begin
        cmd_q   <= CmdNop;
        wb_q    <= 1'b0;
        mem_r_q <= 1'b0;
        mem_w_q <= 1'b0;
        dest_q  <= '0;
        val1_q  <= '0;
        val2_q  <= '0;
        st_q    <= '0;
      end else begin
        cmd_q   <= EXE_CMD;
        wb_q    <= WB_EN;
        mem_r_q <= MEM_R_EN;
        mem_w_q <= MEM_W_EN;
        dest_q  <= dest;
        val1_q  <= val1;
        val2_q  <= val2;
        st_q    <= st_val;
      end
    end
  end

`ifdef EXE_MUL_EN
  logic                mul_done, done_q;
  logic [WORD_LEN-1:0] mul_product;

  // done_q keeps a finished MUL from restarting while it still sits in ID/EXE.
  assign busy = (cmd_q == CmdMul) && !done_q;

  mul_iter u_mul_iter (
    .clk     (clk),
    .rst     (rst),
    .start   (busy),
    .a       (val1_q),
    .b       (val2_q),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          done_q <= 1'b0;
    else if (!busy)    done_q <= 1'b0;
    else if (mul_done) done_q <= 1'b1;
  end

  // The product is captured on the final iteration edge, so the cycle after is a bubble.
  assign out_bubble = (busy && !mul_done) || done_q;
`else
  assign busy       = 1'b0;
  assign out_bubble = 1'b0;
`endif

  always_comb begin
    alu_res = '0;
    case (cmd_q)
      CmdAdd:  alu_res = val1_q + val2_q;
      CmdSub:  alu_res = val1_q - val2_q;
      CmdAnd:  alu_res = val1_q & val2_q;
      CmdOr:   alu_res = val1_q | val2_q;
      CmdXor:  alu_res = val1_q ^ val2_q;
      CmdShl:  alu_res = val1_q << val2_q[3:0];
      CmdShr:  alu_res = val1_q >> val2_q[3:0];
      CmdMov:  alu_res = val2_q;
`ifdef EXE_MUL_EN
      CmdMul:  alu_res = mul_product;
`endif
      default: alu_res = '0;
    endcase
  end

  assign cmd_exec = is_exec_cmd(cmd_q, MulEn);
  assign flag_upd = cmd_exec && (cmd_q != CmdNop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_result   <= '0;
      st_val_EXE   <= '0;
      dest_EXE     <= '0;
      WB_EN_EXE    <= 1'b0;
      MEM_R_EN_EXE <= 1'b0;
      MEM_W_EN_EXE <= 1'b0;
      flagZ        <= 1'b0;
    end else if (out_bubble) begin
      alu_result   <= '0;
      st_val_EXE   <= '0;
      dest_EXE     <= '0;
      WB_EN_EXE    <= 1'b0;
      MEM_R_EN_EXE <= 1'b0;
      MEM_W_EN_EXE <= 1'b0;
    end else begin
      alu_result   <= alu_res;
      st_val_EXE   <= st_q;
      dest_EXE     <= dest_q;
      WB_EN_EXE    <= wb_q && cmd_exec;
      MEM_R_EN_EXE <= mem_r_q;
      MEM_W_EN_EXE <= mem_w_q;
      if (flag_upd) flagZ <= (alu_res == '0);
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed cases plus randomized instructions, checked
// against a per-instruction reference model of the outputs and busy.
module tb_exe_stage;

`ifdef EXE_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, freeze;
  logic [3:0]  EXE_CMD, dest;
  logic        MEM_R_EN, MEM_W_EN, WB_EN;
  logic [15:0] val1, val2, st_val;
  logic [15:0] alu_result, st_val_EXE;
  logic [3:0]  dest_EXE;
  logic        WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE, busy, flagZ;

  exe_stage dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .freeze       (freeze),
    .EXE_CMD      (EXE_CMD),
    .MEM_R_EN     (MEM_R_EN),
    .MEM_W_EN     (MEM_W_EN),
    .WB_EN        (WB_EN),
    .dest         (dest),
    .val1         (val1),
    .val2         (val2),
    .st_val       (st_val),
    .alu_result   (alu_result),
    .st_val_EXE   (st_val_EXE),
    .dest_EXE     (dest_EXE),
    .WB_EN_EXE    (WB_EN_EXE),
    .MEM_R_EN_EXE (MEM_R_EN_EXE),
    .MEM_W_EN_EXE (MEM_W_EN_EXE),
    .busy         (busy),
    .flagZ        (flagZ)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] st;
    logic [3:0]  dest;
    logic        wb;
    logic        mr;
    logic        mw;
    logic        z;
  } out_t;

  out_t out_q[$];
  bit   busy_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  logic model_z = 1'b0;

  function automatic out_t bubble();
    out_t r;
    r   = '0;
    r.z = model_z;
    return r;
  endfunction

  function automatic out_t model_exec(input logic [3:0] cmd, input logic [15:0] a, b, st,
                                      input logic [3:0] d, input logic wb, mr, mw);
    out_t        o;
    int unsigned x, y, r;
    bit          ex;
    x  = a;
    y  = b;
    ex = (cmd <= 8) || (cmd == 9 && MulEn);
    case (cmd)
      1:       r = x + y;
      2:       r = x - y;
      3:       r = x & y;
      4:       r = x | y;
      5:       r = x ^ y;
      6:       r = x << (y % 16);
      7:       r = x >> (y % 16);
      8:       r = y;
      9:       r = MulEn ? x * y : 0;
      default: r = 0;
    endcase
    r = r % 65536;
    if (ex && cmd != 0) model_z = (r == 0);
    o.alu  = 16'(r);
    o.st   = st;
    o.dest = d;
    o.wb   = wb && ex;
    o.mr   = mr;
    o.mw   = mw;
    o.z    = model_z;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  initial begin : monitor
    bit   eb;
    out_t eo, ao;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (busy_q.size() > 0) begin
          eb = busy_q.pop_front();
          n_cmp++;
          if (busy !== eb) begin
            n_err++;
            $display("FAIL busy @%0t: got %b expected %b", $time, busy, eb);
          end
        end
        if (out_q.size() > 0) begin
          eo = out_q.pop_front();
          ao = {alu_result, st_val_EXE, dest_EXE, WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE, flagZ};
          n_cmp++;
          if (ao !== eo) begin
            n_err++;
            $display("FAIL outputs @%0t: got alu=%h st=%h dest=%h wb=%b mr=%b mw=%b z=%b, expected alu=%h st=%h dest=%h wb=%b mr=%b mw=%b z=%b",
                     $time, ao.alu, ao.st, ao.dest, ao.wb, ao.mr, ao.mw, ao.z,
                     eo.alu, eo.st, eo.dest, eo.wb, eo.mr, eo.mw, eo.z);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Called just after a rising edge; the instruction is accepted at the next edge.
  task automatic issue(input logic [3:0] cmd, input logic [15:0] a, b, st, input logic [3:0] d,
                       input logic wb, mr, mw, fl, fr, busy_flush);
    EXE_CMD = cmd; val1 = a; val2 = b; st_val = st; dest = d;
    WB_EN = wb; MEM_R_EN = mr; MEM_W_EN = mw; flush = fl; freeze = fr;
    if (!(fl || fr) && cmd == 9 && MulEn) begin
      for (int i = 0; i < 17; i++) busy_q.push_back(1'b1);
      busy_q.push_back(1'b0);
      for (int i = 0; i < 16; i++) out_q.push_back(bubble());
      out_q.push_back(model_exec(cmd, a, b, st, d, wb, mr, mw));
      out_q.push_back(bubble());
      @(posedge clk); #1;
      // Inputs are junk while the multiply runs; flush/freeze must not disturb it.
      for (int i = 0; i < 17; i++) begin
        EXE_CMD = 4'($urandom); val1 = 16'($urandom); val2 = 16'($urandom);
        st_val = 16'($urandom); dest = 4'($urandom); WB_EN = 1'($urandom);
        MEM_R_EN = 1'($urandom); MEM_W_EN = 1'($urandom);
        flush = busy_flush | 1'($urandom); freeze = 1'($urandom);
        @(posedge clk); #1;
      end
    end else begin
      busy_q.push_back(1'b0);
      out_q.push_back((fl || fr) ? bubble() : model_exec(cmd, a, b, st, d, wb, mr, mw));
      @(posedge clk); #1;
    end
  endtask

  task automatic rand_issue();
    logic [3:0]  c;
    logic [15:0] a, b;
    c = ($urandom_range(0, 99) < 12) ? 4'd9 : 4'($urandom_range(0, 15));
    a = 16'($urandom);
    b = 16'($urandom);
    if ($urandom_range(0, 5) == 0) b = a;
    if ($urandom_range(0, 5) == 0) a = 16'($urandom_range(0, 3));
    issue(c, a, b, 16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, 1'($urandom));
  endtask

  task automatic reset_mid_mul();
    EXE_CMD = 4'd9; val1 = 16'd300; val2 = 16'd3; st_val = 16'h5555; dest = 4'd9;
    WB_EN = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; flush = 1'b0; freeze = 1'b0;
    for (int j = 0; j < 9; j++) busy_q.push_back(MulEn);
    for (int j = 1; j < 9; j++)
      out_q.push_back(MulEn ? bubble() : model_exec(4'd9, 16'd300, 16'd3, 16'h5555, 4'd9,
                                                    1'b1, 1'b0, 1'b0));
    // Acceptance edge, start edge, then eight iteration edges.
    repeat (10) begin @(posedge clk); #1; end
    mon_en = 1'b0;
    chk("busy_before_rst", 64'(busy), 64'(MulEn));
    chk("flagz_before_rst", 64'(flagZ), 64'(model_z));
    #1 rst = 1'b0;
    #1;
    chk("busy_in_rst", 64'(busy), 64'd0);
    chk("outs_in_rst", 64'({alu_result, st_val_EXE, dest_EXE, WB_EN_EXE, MEM_R_EN_EXE,
                            MEM_W_EN_EXE, flagZ}), 64'd0);
    out_q.delete();
    busy_q.delete();
    model_z = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    out_q.push_back('0);
    mon_en = 1'b1;
    issue(4'd1, 16'd1, 16'd1, 16'h0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; freeze = 1'b0; EXE_CMD = '0; dest = '0;
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; WB_EN = 1'b0; val1 = '0; val2 = '0; st_val = '0;
    #1 rst = 1'b0;
    #2;
    chk("busy_reset", 64'(busy), 64'd0);
    chk("outs_reset", 64'({alu_result, st_val_EXE, dest_EXE, WB_EN_EXE, MEM_R_EN_EXE,
                           MEM_W_EN_EXE, flagZ}), 64'd0);
    @(negedge clk); #1;
    rst = 1'b1;
    out_q.push_back('0);
    mon_en = 1'b1;

    //    cmd    a         b         st        d     wb    mr    mw    fl    fr    bfl
    issue(4'd1,  16'd7,    16'd5,    16'h1234, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd2,  16'd9,    16'd9,    16'h0000, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd1,  16'd1,    16'd2,    16'h0000, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(4'd9,  16'd300,  16'd3,    16'hBEEF, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd9,  16'h0100, 16'h0100, 16'h0000, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd1,  16'd7,    16'd5,    16'h0001, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(4'd1,  16'd7,    16'd5,    16'h0002, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(4'd9,  16'd300,  16'd3,    16'h0003, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'd6,  16'h0001, 16'h001F, 16'h0004, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(4'd7,  16'h8000, 16'h0010, 16'h0005, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd12, 16'd5,    16'd5,    16'h0006, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd8,  16'hFFFF, 16'h0000, 16'h0007, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd0,  16'd3,    16'd4,    16'h0008, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd2,  16'd5,    16'd5,    16'h0009, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_mid_mul();

    repeat (150) rand_issue();

    for (int i = 0; i < 4 && (out_q.size() > 0 || busy_q.size() > 0); i++) begin
      @(negedge clk); #1;
    end
    mon_en = 1'b0;
    chk("queues_drained", 64'(out_q.size() + busy_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
